// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one word request at a time and
// holds the returned instruction for IF/ID until it is accepted or flushed.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        fetch_valid,
  output logic [31:0] fetch_count
);

  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_VALID = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  logic [1:0]  state_r, state_s;
  logic [31:0] pc_r, pc_s;
  logic [31:0] instr_r, instr_s;
  logic [31:0] pc_out_r, pc_out_s;
  logic        valid_r, valid_s;
  logic [31:0] count_r, count_s;

  assign imem_req    = (state_r == ST_FETCH);
  assign imem_addr   = {pc_r[31:2], 2'b00};
  assign instr_out   = instr_r;
  assign pc_out      = pc_out_r;
  assign fetch_valid = valid_r;
  assign fetch_count = count_r;

  // Next-state logic; a redirect overrides every other event in the cycle
  always_comb begin
    state_s  = state_r;
    pc_s     = pc_r;
    instr_s  = instr_r;
    pc_out_s = pc_out_r;
    valid_s  = valid_r;
    count_s  = count_r;
    if (redirect_valid) begin
      pc_s    = {redirect_pc[31:2], 2'b00};
      valid_s = 1'b0;
      instr_s = NOP_INSTR;
      // A request already sent (FETCH) or still unanswered must be drained
      case (state_r)
        ST_FETCH: state_s = ST_DRAIN;
        ST_WAIT:  state_s = imem_rvalid ? ST_FETCH : ST_DRAIN;
        ST_VALID: state_s = ST_FETCH;
        ST_DRAIN: state_s = imem_rvalid ? ST_FETCH : ST_DRAIN;
        default:  state_s = ST_FETCH;
      endcase
    end else begin
      case (state_r)
        ST_FETCH: state_s = ST_WAIT;
        ST_WAIT: begin
          if (imem_rvalid) begin
            instr_s  = imem_rdata;
            pc_out_s = pc_r;
            valid_s  = 1'b1;
            state_s  = ST_VALID;
          end else begin
            state_s = ST_WAIT;
          end
        end
        ST_VALID: begin
          if (id_ready) begin
            valid_s = 1'b0;
            instr_s = NOP_INSTR;
            pc_s    = pc_r + 32'd4;
            count_s = count_r + 32'd1;
            state_s = ST_FETCH;
          end else begin
            state_s = ST_VALID;
          end
        end
        ST_DRAIN: begin
          if (imem_rvalid) begin
            state_s = ST_FETCH;
          end else begin
            state_s = ST_DRAIN;
          end
        end
        default: state_s = ST_FETCH;
      endcase
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= ST_FETCH;
      pc_r     <= RESET_PC;
      instr_r  <= NOP_INSTR;
      pc_out_r <= 32'd0;
      valid_r  <= 1'b0;
      count_r  <= 32'd0;
    end else begin
      state_r  <= state_s;
      pc_r     <= pc_s;
      instr_r  <= instr_s;
      pc_out_r <= pc_out_s;
      valid_r  <= valid_s;
      count_r  <= count_s;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: a latency-programmable memory model checks
// request addresses, and a monitor checks every instruction presented to IF/ID.
module tb_if_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        fetch_valid;
  logic [31:0] fetch_count;

  int checks = 0;
  int failures = 0;
  int mem_lat = 1;

  logic [31:0] exp_addr_q[$];
  logic [63:0] exp_ins_q[$];

  if_fetch_unit dut (
    .clk(clk), .reset(reset), .id_ready(id_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instr_out(instr_out), .pc_out(pc_out),
    .fetch_valid(fetch_valid), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] dat(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string name, input logic ok,
                       input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [31:0] a, input logic with_instr);
    exp_addr_q.push_back(a);
    if (with_instr) exp_ins_q.push_back({a, dat(a)});
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (!fetch_valid && n < 20) begin
      step();
      n++;
    end
    check(name, fetch_valid, {31'd0, fetch_valid}, 32'd1);
  endtask

  // Memory model: a request seen before an edge answers mem_lat edges later
  initial begin : mem_model
    logic        busy;
    int          cnt;
    logic [31:0] addr;
    logic [31:0] ea;
    busy = 1'b0;
    cnt = 0;
    addr = 32'd0;
    forever begin
      @(negedge clk);
      imem_rvalid = 1'b0;
      if (busy) begin
        cnt--;
        if (cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata  = dat(addr);
          busy = 1'b0;
        end
      end
      if (imem_req && !reset) begin
        check("single_outstanding", !busy, {31'd0, busy}, 32'd0);
        ea = (exp_addr_q.size() > 0) ? exp_addr_q.pop_front() : 32'hDEAD_BEEF;
        check("req_addr", imem_addr == ea, imem_addr, ea);
        busy = 1'b1;
        cnt = mem_lat;
        addr = imem_addr;
      end
    end
  end

  // Monitor: pops an expectation when an instruction appears, holds it while valid
  initial begin : monitor
    logic        prev;
    logic [63:0] cur;
    prev = 1'b0;
    cur = 64'd0;
    forever begin
      @(negedge clk);
      if (fetch_valid) begin
        if (!prev) begin
          check("unexpected_instr", exp_ins_q.size() > 0, instr_out, 32'd0);
          cur = (exp_ins_q.size() > 0) ? exp_ins_q.pop_front() : 64'd0;
        end
        check("pc_out", pc_out == cur[63:32], pc_out, cur[63:32]);
        check("instr_out", instr_out == cur[31:0], instr_out, cur[31:0]);
      end else begin
        check("instr_nop", instr_out == NOP, instr_out, NOP);
      end
      prev = fetch_valid;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int vcnt;
    reset = 1'b1;
    id_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'd0;
    imem_rvalid = 1'b0;
    imem_rdata = 32'd0;
    repeat (3) step();
    check("rst_valid", fetch_valid == 1'b0, {31'd0, fetch_valid}, 32'd0);
    check("rst_pc_out", pc_out == 32'd0, pc_out, 32'd0);
    check("rst_count", fetch_count == 32'd0, fetch_count, 32'd0);
    check("rst_addr", imem_addr == 32'd0, imem_addr, 32'd0);

    // L=1 stream with id_ready held high
    push(32'd0, 1'b1); push(32'd4, 1'b1); push(32'd8, 1'b1);
    reset = 1'b0;
    vcnt = 0;
    for (int i = 0; i < 9; i++) begin
      step();
      if (fetch_valid) vcnt++;
    end
    check("valid_duty", vcnt == 3, vcnt, 32'd3);
    check("count_3", fetch_count == 32'd3, fetch_count, 32'd3);

    // L=3: valid exactly 3 cycles after request, no second request in WAIT
    mem_lat = 3;
    push(32'd12, 1'b1);
    id_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      check("l3_valid", fetch_valid == (i == 4), {31'd0, fetch_valid}, {31'd0, i == 4});
      check("l3_noreq", imem_req == 1'b0, {31'd0, imem_req}, 32'd0);
    end

    // Stall for 5 cycles
    for (int i = 0; i < 5; i++) begin
      step();
      check("stall_noreq", imem_req == 1'b0, {31'd0, imem_req}, 32'd0);
      check("stall_count", fetch_count == 32'd3, fetch_count, 32'd3);
    end
    id_ready = 1'b1;
    push(32'd16, 1'b1);
    step();
    check("acc_count", fetch_count == 32'd4, fetch_count, 32'd4);
    check("acc_addr", imem_req && imem_addr == 32'd16, imem_addr, 32'd16);
    for (int i = 1; i <= 4; i++) begin
      step();
      check("l3b_valid", fetch_valid == (i == 4), {31'd0, fetch_valid}, {31'd0, i == 4});
    end
    push(32'd20, 1'b1);
    for (int i = 1; i <= 5; i++) begin
      step();
      check("period5", fetch_valid == (i == 5), {31'd0, fetch_valid}, {31'd0, i == 5});
    end

    // Redirect while waiting for a response
    push(32'd24, 1'b0);
    step();
    check("count_6", fetch_count == 32'd6, fetch_count, 32'd6);
    step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    id_ready = 1'b0;
    push(32'h100, 1'b1);
    step();
    redirect_valid = 1'b0;
    check("drain_noreq", imem_req == 1'b0, {31'd0, imem_req}, 32'd0);
    step();
    check("drain_noreq2", imem_req == 1'b0, {31'd0, imem_req}, 32'd0);
    step();
    check("post_drain_addr", imem_req && imem_addr == 32'h100, imem_addr, 32'h100);
    wait_valid("wait_100");
    check("redir_count", fetch_count == 32'd6, fetch_count, 32'd6);

    // Redirect coincident with the response, unaligned target
    id_ready = 1'b1;
    push(32'h104, 1'b0);
    step();
    id_ready = 1'b0;
    check("count_7", fetch_count == 32'd7, fetch_count, 32'd7);
    repeat (3) step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h103;
    push(32'h100, 1'b1);
    step();
    redirect_valid = 1'b0;
    check("coinc_addr", imem_req && imem_addr == 32'h100, imem_addr, 32'h100);
    check("coinc_count", fetch_count == 32'd7, fetch_count, 32'd7);
    wait_valid("wait_coinc");

    // Redirect in VALID with id_ready high: not counted
    id_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    push(32'h200, 1'b1);
    step();
    redirect_valid = 1'b0;
    id_ready = 1'b0;
    check("valid_redir_count", fetch_count == 32'd7, fetch_count, 32'd7);
    check("valid_redir_addr", imem_req && imem_addr == 32'h200, imem_addr, 32'h200);
    wait_valid("wait_200");

    // Reset in WAIT; stale response lands in FETCH after release
    id_ready = 1'b1;
    push(32'h204, 1'b0);
    step();
    id_ready = 1'b0;
    check("count_8", fetch_count == 32'd8, fetch_count, 32'd8);
    step();
    reset = 1'b1;
    #1;
    check("mid_rst_count", fetch_count == 32'd0, fetch_count, 32'd0);
    check("mid_rst_addr", imem_addr == 32'd0, imem_addr, 32'd0);
    check("mid_rst_instr", instr_out == NOP, instr_out, NOP);
    push(32'd0, 1'b1);
    step();
    step();
    reset = 1'b0;
    wait_valid("wait_after_rst");

    // PC wrap from the top of the address space
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    push(32'hFFFF_FFFC, 1'b1);
    step();
    redirect_valid = 1'b0;
    wait_valid("wait_top");
    id_ready = 1'b1;
    push(32'd0, 1'b1);
    step();
    id_ready = 1'b0;
    check("wrap_count", fetch_count == 32'd1, fetch_count, 32'd1);
    check("wrap_addr", imem_req && imem_addr == 32'd0, imem_addr, 32'd0);
    wait_valid("wait_wrap");
    repeat (3) step();
    check("addr_q_empty", exp_addr_q.size() == 0, exp_addr_q.size(), 32'd0);
    check("ins_q_empty", exp_ins_q.size() == 0, exp_ins_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
